// File: rtl/assoc_tlb_ctrl.sv
// assoc_tlb_ctrl: fully associative, ASID-tagged TLB with a single-outstanding miss FSM refilling from a PTW.
// Latency: hit response 2 cycles after request acceptance; miss response 1 cycle after ptw_resp_valid.
// Backpressure: req_ready only in IDLE; PTW request held stable until ptw_req_ready; responses never stall.
// Optional build macro TLB_PERF_CNT_EN adds saturating 32-bit hit/miss counters (outputs read 0 otherwise).
module assoc_tlb_ctrl #(
  parameter int ENTRY_NUM         = 16,
  parameter int VPN_WIDTH         = 20,
  parameter int PPN_WIDTH         = 20,
  parameter int PAGE_OFFSET_WIDTH = 12,
  parameter int ASID_WIDTH        = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [VPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] req_vaddr,
  input  logic [ASID_WIDTH-1:0]                req_asid,
  output logic                                 resp_valid,
  output logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] resp_paddr,
  output logic                                 resp_fault,
  output logic                                 resp_hit,
  output logic                                 ptw_req_valid,
  input  logic                                 ptw_req_ready,
  output logic [VPN_WIDTH-1:0]                 ptw_req_vpn,
  output logic [ASID_WIDTH-1:0]                ptw_req_asid,
  input  logic                                 ptw_resp_valid,
  input  logic [PPN_WIDTH-1:0]                 ptw_resp_ppn,
  input  logic                                 ptw_resp_fault,
  input  logic                                 flush,
  input  logic                                 flush_asid_only,
  input  logic [ASID_WIDTH-1:0]                flush_asid,
  output logic [31:0]                          hit_count,
  output logic [31:0]                          miss_count
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_WALK_REQ, S_WALK_WAIT} state_t;

  state_t                         r_state, w_state_nxt;
  logic [VPN_WIDTH-1:0]           r_vpn;
  logic [PAGE_OFFSET_WIDTH-1:0]   r_off;
  logic [ASID_WIDTH-1:0]          r_asid;
  logic [ENTRY_NUM-1:0]           r_ent_vld;
  logic [VPN_WIDTH-1:0]           r_ent_vpn  [ENTRY_NUM];
  logic [ASID_WIDTH-1:0]          r_ent_asid [ENTRY_NUM];
  logic [PPN_WIDTH-1:0]           r_ent_ppn  [ENTRY_NUM];
  logic [IDX_W-1:0]               r_rr_ptr;
  logic                           r_drop;
  logic                           r_resp_valid, r_resp_fault, r_resp_hit;
  logic [PPN_WIDTH+PAGE_OFFSET_WIDTH-1:0] r_resp_paddr;

  logic                           w_hit;
  logic [PPN_WIDTH-1:0]           w_hit_ppn;
  logic                           w_has_inv;
  logic [IDX_W-1:0]               w_victim;
  logic [ENTRY_NUM-1:0]           w_flush_sel;
  logic                           w_walk_done;
  logic                           w_fill;
  logic                           w_in_walk;

  // Tag match against the captured request; descending scan so the lowest matching index wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_ppn = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (r_ent_vld[i] && r_ent_vpn[i] == r_vpn && r_ent_asid[i] == r_asid) begin
        w_hit     = 1'b1;
        w_hit_ppn = r_ent_ppn[i];
      end
    end
  end

  // Victim: lowest invalid slot if any, otherwise the round-robin pointer.
  always_comb begin
    w_has_inv = 1'b0;
    w_victim  = r_rr_ptr;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!r_ent_vld[i]) begin
        w_has_inv = 1'b1;
        w_victim  = IDX_W'(i);
      end
    end
  end

  // Entries hit by the flush: all of them, or only those tagged with flush_asid.
  always_comb begin
    for (int i = 0; i < ENTRY_NUM; i++) begin
      w_flush_sel[i] = !flush_asid_only || (r_ent_asid[i] == flush_asid);
    end
  end

  assign w_walk_done = (r_state == S_WALK_WAIT) && ptw_resp_valid;
  assign w_in_walk   = (r_state == S_WALK_REQ) || (r_state == S_WALK_WAIT);
  // A flush in the same cycle, or one seen earlier in this walk, suppresses the fill.
  assign w_fill      = w_walk_done && !ptw_resp_fault && !r_drop && !flush;

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    req_ready     = 1'b0;
    ptw_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP:    w_state_nxt = w_hit ? S_IDLE : S_WALK_REQ;
      S_WALK_REQ: begin
        ptw_req_valid = 1'b1;
        if (ptw_req_ready) w_state_nxt = S_WALK_WAIT;
      end
      S_WALK_WAIT: if (ptw_resp_valid) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // State register, request capture, drop flag and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vpn        <= '0;
      r_off        <= '0;
      r_asid       <= '0;
      r_drop       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_paddr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_resp_hit   <= 1'b0;
      if (r_state == S_IDLE && req_valid) begin
        r_vpn  <= req_vaddr[VPN_WIDTH+PAGE_OFFSET_WIDTH-1:PAGE_OFFSET_WIDTH];
        r_off  <= req_vaddr[PAGE_OFFSET_WIDTH-1:0];
        r_asid <= req_asid;
      end
      if (w_state_nxt == S_IDLE)  r_drop <= 1'b0;
      else if (flush && w_in_walk) r_drop <= 1'b1;
      if (r_state == S_LOOKUP && w_hit) begin
        r_resp_valid <= 1'b1;
        r_resp_hit   <= 1'b1;
        r_resp_paddr <= {w_hit_ppn, r_off};
      end else if (w_walk_done) begin
        r_resp_valid <= 1'b1;
        r_resp_fault <= ptw_resp_fault;
        r_resp_paddr <= ptw_resp_fault ? '0 : {ptw_resp_ppn, r_off};
      end
    end
  end

  // Valid bits and round-robin pointer; flush takes priority over a fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent_vld <= '0;
      r_rr_ptr  <= '0;
    end else if (flush) begin
      r_ent_vld <= r_ent_vld & ~w_flush_sel;
    end else if (w_fill) begin
      r_ent_vld[w_victim] <= 1'b1;
      if (!w_has_inv) r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end

  // Entry payload; only meaningful while the valid bit is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_ent_vpn[w_victim]  <= r_vpn;
      r_ent_asid[w_victim] <= r_asid;
      r_ent_ppn[w_victim]  <= ptw_resp_ppn;
    end
  end

  assign resp_valid   = r_resp_valid;
  assign resp_paddr   = r_resp_paddr;
  assign resp_fault   = r_resp_fault;
  assign resp_hit     = r_resp_hit;
  assign ptw_req_vpn  = r_vpn;
  assign ptw_req_asid = r_asid;

`ifdef TLB_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  // Saturating lookup outcome counters; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit && r_hit_cnt != 32'hFFFF_FFFF)   r_hit_cnt  <= r_hit_cnt + 32'd1;
      if (!w_hit && r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_assoc_tlb_ctrl.sv
// tb_assoc_tlb_ctrl: directed vectors against assoc_tlb_ctrl with a scripted page-table walker.
// Latency: checks hit response 2 cycles after acceptance and miss response after the walk.
// Backpressure: walker can hold ptw_req_ready low and delay its response to exercise stalls.
module tb_assoc_tlb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_vaddr = '0;
  logic [7:0]  req_asid = '0;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_fault;
  logic        resp_hit;
  logic        ptw_req_valid;
  logic        ptw_req_ready = 1'b0;
  logic [19:0] ptw_req_vpn;
  logic [7:0]  ptw_req_asid;
  logic        ptw_resp_valid = 1'b0;
  logic [19:0] ptw_resp_ppn = '0;
  logic        ptw_resp_fault = 1'b0;
  logic        flush = 1'b0;
  logic        flush_asid_only = 1'b0;
  logic [7:0]  flush_asid = '0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_tests = 0;
  int n_fail  = 0;

  // walker script for the next translation
  int          opt_ready_dly = 0;
  int          opt_resp_dly  = 0;
  bit          opt_flush_wait = 1'b0;
  logic [19:0] opt_ppn = '0;
  logic        opt_fault = 1'b0;

  // observed result of the last translation
  logic [31:0] o_paddr;
  logic        o_hit, o_fault, o_walked;
  int          o_lat;

  int exp_hit = 0;
  int exp_miss = 0;

  assoc_tlb_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr), .req_asid(req_asid),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_fault(resp_fault), .resp_hit(resp_hit),
    .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
    .ptw_req_asid(ptw_req_asid), .ptw_resp_valid(ptw_resp_valid), .ptw_resp_ppn(ptw_resp_ppn),
    .ptw_resp_fault(ptw_resp_fault), .flush(flush), .flush_asid_only(flush_asid_only),
    .flush_asid(flush_asid), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    req_valid = 1'b0; ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_paddr", resp_paddr, 32'h0);
    check("rst_resp_fault", resp_fault, 1'b0);
    check("rst_resp_hit", resp_hit, 1'b0);
    check("rst_ptw_req_valid", ptw_req_valid, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
  endtask

  task automatic do_flush(input logic asid_only, input logic [7:0] asid);
    @(negedge clk);
    flush = 1'b1; flush_asid_only = asid_only; flush_asid = asid;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // One request through the DUT, acting as the walker per the opt_* script.
  task automatic translate(input logic [31:0] va, input logic [7:0] asid);
    int phase, rdy_cnt, wcnt;
    bit done;
    phase = 0; rdy_cnt = 0; wcnt = 0; done = 1'b0;
    o_walked = 1'b0; o_hit = 1'b0; o_fault = 1'b0; o_paddr = '0; o_lat = 0;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_vaddr = va; req_asid = asid;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c < 80 && !done; c++) begin
      @(negedge clk);
      ptw_resp_valid = 1'b0;
      flush = 1'b0;
      if (resp_valid) begin
        o_paddr = resp_paddr; o_hit = resp_hit; o_fault = resp_fault; o_lat = c;
        done = 1'b1;
        ptw_req_ready = 1'b0;
      end else begin
        case (phase)
          0: if (ptw_req_valid) begin
            o_walked = 1'b1;
            check("ptw_req_vpn", ptw_req_vpn, va[31:12]);
            check("ptw_req_asid", ptw_req_asid, asid);
            check("req_ready_busy", req_ready, 1'b0);
            if (rdy_cnt >= opt_ready_dly) begin
              ptw_req_ready = 1'b1;
              phase = 1;
            end else rdy_cnt++;
          end
          1: begin
            ptw_req_ready = 1'b0;
            check("ptw_req_released", ptw_req_valid, 1'b0);
            if (opt_flush_wait && wcnt == 0) begin
              flush = 1'b1; flush_asid_only = 1'b0;
            end
            if (wcnt >= opt_resp_dly) begin
              ptw_resp_valid = 1'b1; ptw_resp_ppn = opt_ppn; ptw_resp_fault = opt_fault;
              phase = 2;
            end else wcnt++;
          end
          default: ;
        endcase
      end
    end
    ptw_resp_valid = 1'b0; flush = 1'b0; ptw_req_ready = 1'b0;
    check("resp_arrived", done, 1'b1);
    if (done) begin
      @(negedge clk);
      check("resp_single_pulse", resp_valid, 1'b0);
      if (o_walked) exp_miss++;
      else if (o_hit) exp_hit++;
    end
  endtask

  task automatic check_counters(input string tag);
`ifdef TLB_PERF_CNT_EN
    check({tag, "_hits"}, hit_count, 32'(exp_hit));
    check({tag, "_misses"}, miss_count, 32'(exp_miss));
`else
    check({tag, "_hits"}, hit_count, 32'h0);
    check({tag, "_misses"}, miss_count, 32'h0);
`endif
  endtask

  initial begin
    int seen;
    reset_dut();

    // cold miss then hit
    opt_ppn = 20'h00077; opt_fault = 1'b0;
    translate(32'h12345ABC, 8'd3);
    check("cold_walked", o_walked, 1'b1);
    check("cold_paddr", o_paddr, 32'h00077ABC);
    check("cold_hit", o_hit, 1'b0);
    check("cold_fault", o_fault, 1'b0);
    check("cold_lat", o_lat, 32'd4);
    translate(32'h12345ABC, 8'd3);
    check("rehit_walked", o_walked, 1'b0);
    check("rehit_hit", o_hit, 1'b1);
    check("rehit_paddr", o_paddr, 32'h00077ABC);
    check("rehit_lat", o_lat, 32'd2);

    // asid isolation and selective flush
    opt_ppn = 20'h00088;
    translate(32'h12345ABC, 8'd4);
    check("asid4_walked", o_walked, 1'b1);
    check("asid4_paddr", o_paddr, 32'h00088ABC);
    do_flush(1'b1, 8'd3);
    translate(32'h12345ABC, 8'd4);
    check("asid4_survives", o_hit, 1'b1);
    check("asid4_hit_paddr", o_paddr, 32'h00088ABC);
    opt_ppn = 20'h00077;
    translate(32'h12345ABC, 8'd3);
    check("asid3_flushed", o_walked, 1'b1);
    check_counters("cnt_a");

    // fault: no fill, retry walks again
    opt_fault = 1'b1; opt_ppn = 20'h00055;
    translate(32'h0ABCD123, 8'd5);
    check("fault_flag", o_fault, 1'b1);
    check("fault_paddr", o_paddr, 32'h0);
    check("fault_hit", o_hit, 1'b0);
    opt_fault = 1'b0;
    translate(32'h0ABCD123, 8'd5);
    check("fault_retry_walked", o_walked, 1'b1);
    check("fault_retry_paddr", o_paddr, 32'h00055123);

    // flush during walk with stalled walker
    opt_ppn = 20'h00099; opt_ready_dly = 5; opt_resp_dly = 1; opt_flush_wait = 1'b1;
    translate(32'h00042010, 8'd6);
    check("fwalk_paddr", o_paddr, 32'h00099010);
    check("fwalk_fault", o_fault, 1'b0);
    opt_ready_dly = 0; opt_resp_dly = 0; opt_flush_wait = 1'b0;
    translate(32'h00042010, 8'd6);
    check("fwalk_no_fill", o_walked, 1'b1);
    translate(32'h00042010, 8'd6);
    check("fwalk_refilled", o_hit, 1'b1);

    // replacement
    reset_dut();
    for (int v = 0; v < 18; v++) begin
      opt_ppn = 20'(32'h100 + v);
      translate({v[19:0], 12'h5A5}, 8'd1);
      check($sformatf("fill_%0d_walked", v), o_walked, 1'b1);
    end
    translate({20'h10, 12'h5A5}, 8'd1);
    check("repl_0x10_hit", o_hit, 1'b1);
    check("repl_0x10_paddr", o_paddr, 32'h001105A5);
    translate({20'h11, 12'h5A5}, 8'd1);
    check("repl_0x11_hit", o_hit, 1'b1);
    translate({20'h2, 12'h5A5}, 8'd1);
    check("repl_0x2_hit", o_hit, 1'b1);
    check("repl_0x2_paddr", o_paddr, 32'h001025A5);
    translate({20'h3, 12'h5A5}, 8'd1);
    check("repl_0x3_hit", o_hit, 1'b1);
    opt_ppn = 20'h100;
    translate({20'h0, 12'h5A5}, 8'd1);
    check("repl_0x0_evicted", o_walked, 1'b1);
    check_counters("cnt_b");

    // reset in WALK_WAIT, late walker response ignored
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = 32'hABCDE000; req_asid = 8'd2;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      @(negedge clk);
      if (ptw_req_valid) seen = 1;
    end
    check("rmw_walk_issued", seen, 32'd1);
    ptw_req_ready = 1'b1;
    @(negedge clk);
    ptw_req_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_hit = 0; exp_miss = 0;
    @(negedge clk);
    ptw_resp_valid = 1'b1; ptw_resp_ppn = 20'h00ABC; ptw_resp_fault = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ptw_resp_valid = 1'b0;
      if (resp_valid) seen++;
    end
    check("rmw_no_resp", seen, 32'd0);
    check("rmw_req_ready", req_ready, 1'b1);
    check("rmw_ptw_idle", ptw_req_valid, 1'b0);
    opt_ppn = 20'h00123;
    translate({20'h2, 12'h5A5}, 8'd1);
    check("rmw_0x2_miss", o_walked, 1'b1);
    translate(32'hABCDE000, 8'd2);
    check("rmw_late_no_fill", o_walked, 1'b1);
    check_counters("cnt_c");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
